// File: rtl/ysyx_22051013_muldiv_ctrl.sv
// Purpose  : sequences one M-extension op at a time onto the shared booth multiplier / radix-2 divider
// Latency  : accept->out_valid = 2 + unit handshake wait + unit compute; div-by-zero/overflow/illegal = 1
// Backpress: in_ready low while busy; x_valid held with stable operands until x_ready; result held until out_ready
//
// Ports:
//   i_clk, i_rst_n                 clock, asynchronous active-low reset
//   i_in_valid/o_in_ready          operation offer handshake (i_in_op, i_in_op1, i_in_op2)
//   i_flush / o_unit_flush         abort in-flight op / abort forwarded to both units
//   o_mul_valid/i_mul_ready        multiplier issue (o_mul_signed, o_mulw)
//   i_mul_out_valid                multiplier done (i_result_hi, i_result_lo)
//   o_div_valid/i_div_ready        divider issue (o_div_signed, o_divw)
//   i_div_out_valid                divider done (i_quotient, i_remainder)
//   o_mul_op1, o_mul_op2           latched operands, shared by both units
//   o_out_valid/i_out_ready        result handshake (o_out_res)
//   o_busy                         state != IDLE, execute-stage stall
module ysyx_22051013_muldiv_ctrl #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_in_valid,
    output logic            o_in_ready,
    input  logic [3:0]      i_in_op,
    input  logic [XLEN-1:0] i_in_op1,
    input  logic [XLEN-1:0] i_in_op2,
    input  logic            i_flush,
    output logic            o_mul_valid,
    input  logic            i_mul_ready,
    output logic [1:0]      o_mul_signed,
    output logic            o_mulw,
    input  logic            i_mul_out_valid,
    input  logic [XLEN-1:0] i_result_hi,
    input  logic [XLEN-1:0] i_result_lo,
    output logic            o_div_valid,
    input  logic            i_div_ready,
    output logic            o_div_signed,
    output logic            o_divw,
    input  logic            i_div_out_valid,
    input  logic [XLEN-1:0] i_quotient,
    input  logic [XLEN-1:0] i_remainder,
    output logic            o_unit_flush,
    output logic [XLEN-1:0] o_mul_op1,
    output logic [XLEN-1:0] o_mul_op2,
    output logic            o_out_valid,
    input  logic            i_out_ready,
    output logic [XLEN-1:0] o_out_res,
    output logic            o_busy
);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_ISSUE_MUL = 3'd1;
    localparam logic [2:0] S_WAIT_MUL  = 3'd2;
    localparam logic [2:0] S_ISSUE_DIV = 3'd3;
    localparam logic [2:0] S_WAIT_DIV  = 3'd4;
    localparam logic [2:0] S_DONE      = 3'd5;

    localparam logic [3:0] OP_MUL    = 4'd0;
    localparam logic [3:0] OP_MULH   = 4'd1;
    localparam logic [3:0] OP_MULHSU = 4'd2;
    localparam logic [3:0] OP_MULHU  = 4'd3;
    localparam logic [3:0] OP_MULW   = 4'd4;
    localparam logic [3:0] OP_DIV    = 4'd5;
    localparam logic [3:0] OP_DIVU   = 4'd6;
    localparam logic [3:0] OP_REM    = 4'd7;
    localparam logic [3:0] OP_REMU   = 4'd8;
    localparam logic [3:0] OP_DIVW   = 4'd9;
    localparam logic [3:0] OP_DIVUW  = 4'd10;
    localparam logic [3:0] OP_REMW   = 4'd11;
    localparam logic [3:0] OP_REMUW  = 4'd12;

    localparam logic [XLEN-1:0] ALL_ONES  = {XLEN{1'b1}};
    localparam logic [XLEN-1:0] INT_MIN   = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] INT32_MIN = {{(XLEN-31){1'b1}}, 31'd0};

    function automatic logic f_is_w(input logic [3:0] op);
        return (op == OP_DIVW) || (op == OP_DIVUW) || (op == OP_REMW) || (op == OP_REMUW);
    endfunction

    function automatic logic f_is_rem(input logic [3:0] op);
        return (op == OP_REM) || (op == OP_REMU) || (op == OP_REMW) || (op == OP_REMUW);
    endfunction

    function automatic logic f_is_sdiv(input logic [3:0] op);
        return (op == OP_DIV) || (op == OP_REM) || (op == OP_DIVW) || (op == OP_REMW);
    endfunction

    function automatic logic [XLEN-1:0] f_sext32(input logic [XLEN-1:0] v);
        return {{(XLEN-32){v[31]}}, v[31:0]};
    endfunction

    logic [2:0]      r_state;
    logic [2:0]      w_state_nxt;
    logic [3:0]      r_op;
    logic [XLEN-1:0] r_op1;
    logic [XLEN-1:0] r_op2;
    logic [XLEN-1:0] r_res;
    logic [XLEN-1:0] w_res_nxt;
    logic            r_alive;
    logic [1:0]      r_mul_signed;
    logic            r_mulw;
    logic            r_div_signed;
    logic            r_divw;

    logic            w_accept;
    logic            w_in_is_mul;
    logic            w_in_is_div;
    logic            w_in_w;
    logic            w_in_rem;
    logic            w_in_sdiv;
    logic            w_div_zero;
    logic            w_div_ovf;
    logic [XLEN-1:0] w_special_res;
    logic [1:0]      w_in_mul_signed;
    logic [XLEN-1:0] w_mul_sel;
    logic [XLEN-1:0] w_div_sel;

    // r_alive keeps in_ready low until the first edge after reset release
    assign o_in_ready   = r_alive && (r_state == S_IDLE) && !i_flush;
    assign w_accept     = i_in_valid && o_in_ready;

    assign w_in_is_mul  = (i_in_op <= OP_MULW);
    assign w_in_is_div  = (i_in_op >= OP_DIV) && (i_in_op <= OP_REMUW);
    assign w_in_w       = f_is_w(i_in_op);
    assign w_in_rem     = f_is_rem(i_in_op);
    assign w_in_sdiv    = f_is_sdiv(i_in_op);

    assign w_div_zero   = w_in_w ? (i_in_op2[31:0] == 32'd0) : (i_in_op2 == '0);
    assign w_div_ovf    = w_in_sdiv &&
                          (w_in_w ? ((i_in_op1[31:0] == 32'h8000_0000) && (i_in_op2[31:0] == 32'hFFFF_FFFF))
                                  : ((i_in_op1 == INT_MIN) && (i_in_op2 == ALL_ONES)));

    // Resolved results for ops that never reach the divider
    always_comb begin
        w_special_res = '0;
        if (w_div_zero) begin
            if (w_in_rem) w_special_res = w_in_w ? f_sext32(i_in_op1) : i_in_op1;
            else          w_special_res = ALL_ONES;
        end else if (w_div_ovf) begin
            if (w_in_rem) w_special_res = '0;
            else          w_special_res = w_in_w ? INT32_MIN : i_in_op1;
        end
    end

    always_comb begin
        case (i_in_op)
            OP_MULHSU: w_in_mul_signed = 2'b10;
            OP_MULHU:  w_in_mul_signed = 2'b00;
            default:   w_in_mul_signed = 2'b11;
        endcase
    end

    always_comb begin
        case (r_op)
            OP_MUL:  w_mul_sel = i_result_lo;
            OP_MULW: w_mul_sel = f_sext32(i_result_lo);
            default: w_mul_sel = i_result_hi;
        endcase
    end

    always_comb begin
        w_div_sel = f_is_rem(r_op) ? i_remainder : i_quotient;
        if (f_is_w(r_op)) w_div_sel = f_sext32(w_div_sel);
    end

    always_comb begin
        w_state_nxt = r_state;
        w_res_nxt   = r_res;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_in_is_mul) begin
                        w_state_nxt = S_ISSUE_MUL;
                    end else if (w_in_is_div && !w_div_zero && !w_div_ovf) begin
                        w_state_nxt = S_ISSUE_DIV;
                    end else begin
                        // special division case, or illegal op resolving to 0
                        w_state_nxt = S_DONE;
                        w_res_nxt   = w_in_is_div ? w_special_res : '0;
                    end
                end
            end
            S_ISSUE_MUL: if (i_mul_ready) w_state_nxt = S_WAIT_MUL;
            S_WAIT_MUL: begin
                if (i_mul_out_valid) begin
                    w_state_nxt = S_DONE;
                    w_res_nxt   = w_mul_sel;
                end
            end
            S_ISSUE_DIV: if (i_div_ready) w_state_nxt = S_WAIT_DIV;
            S_WAIT_DIV: begin
                if (i_div_out_valid) begin
                    w_state_nxt = S_DONE;
                    w_res_nxt   = w_div_sel;
                end
            end
            S_DONE: if (i_out_ready) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
        // flush wins over issue and capture; held result is simply dropped
        if (i_flush) begin
            w_state_nxt = S_IDLE;
            w_res_nxt   = r_res;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= S_IDLE;
            r_alive      <= 1'b0;
            r_op         <= '0;
            r_op1        <= '0;
            r_op2        <= '0;
            r_res        <= '0;
            r_mul_signed <= 2'b00;
            r_mulw       <= 1'b0;
            r_div_signed <= 1'b0;
            r_divw       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_alive <= 1'b1;
            r_res   <= w_res_nxt;
            if (w_accept) begin
                r_op         <= i_in_op;
                r_op1        <= i_in_op1;
                r_op2        <= i_in_op2;
                r_mul_signed <= w_in_is_mul ? w_in_mul_signed : 2'b00;
                r_mulw       <= (i_in_op == OP_MULW);
                r_div_signed <= w_in_is_div && w_in_sdiv;
                r_divw       <= w_in_is_div && w_in_w;
            end
        end
    end

    assign o_mul_valid  = (r_state == S_ISSUE_MUL);
    assign o_div_valid  = (r_state == S_ISSUE_DIV);
    assign o_mul_signed = r_mul_signed;
    assign o_mulw       = r_mulw;
    assign o_div_signed = r_div_signed;
    assign o_divw       = r_divw;
    assign o_mul_op1    = r_op1;
    assign o_mul_op2    = r_op2;
    assign o_unit_flush = i_flush && (r_state != S_IDLE) && (r_state != S_DONE);
    assign o_out_valid  = (r_state == S_DONE);
    assign o_out_res    = r_res;
    assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_ysyx_22051013_muldiv_ctrl.sv
// Purpose  : directed self-checking bench for ysyx_22051013_muldiv_ctrl
// Latency  : checks single-cycle special cases and handshake-dependent unit paths
// Backpress: exercises held div_ready / out_ready and flush/reset aborts
module tb_ysyx_22051013_muldiv_ctrl;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_in_valid, i_flush, i_mul_ready, i_mul_out_valid;
    logic        i_div_ready, i_div_out_valid, i_out_ready;
    logic [3:0]  i_in_op;
    logic [63:0] i_in_op1, i_in_op2, i_result_hi, i_result_lo, i_quotient, i_remainder;
    logic        o_in_ready, o_mul_valid, o_mulw, o_div_valid, o_div_signed, o_divw;
    logic        o_unit_flush, o_out_valid, o_busy;
    logic [1:0]  o_mul_signed;
    logic [63:0] o_mul_op1, o_mul_op2, o_out_res;

    int n_chk = 0;
    int n_err = 0;

    ysyx_22051013_muldiv_ctrl #(.XLEN(64)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_op(i_in_op),
        .i_in_op1(i_in_op1), .i_in_op2(i_in_op2), .i_flush(i_flush),
        .o_mul_valid(o_mul_valid), .i_mul_ready(i_mul_ready), .o_mul_signed(o_mul_signed),
        .o_mulw(o_mulw), .i_mul_out_valid(i_mul_out_valid),
        .i_result_hi(i_result_hi), .i_result_lo(i_result_lo),
        .o_div_valid(o_div_valid), .i_div_ready(i_div_ready), .o_div_signed(o_div_signed),
        .o_divw(o_divw), .i_div_out_valid(i_div_out_valid),
        .i_quotient(i_quotient), .i_remainder(i_remainder),
        .o_unit_flush(o_unit_flush), .o_mul_op1(o_mul_op1), .o_mul_op2(o_mul_op2),
        .o_out_valid(o_out_valid), .i_out_ready(i_out_ready), .o_out_res(o_out_res),
        .o_busy(o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Special cases and illegal ops: done one cycle after accept, divider untouched
    task automatic run_special(input string tag, input logic [3:0] op,
                               input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp);
        i_in_valid = 1'b1; i_in_op = op; i_in_op1 = a; i_in_op2 = b;
        #1 chk({tag, "_accept"}, {63'd0, o_in_ready}, 64'd1);
        tick;
        i_in_valid = 1'b0;
        #1;
        chk({tag, "_out_valid"}, {63'd0, o_out_valid}, 64'd1);
        chk({tag, "_res"}, o_out_res, exp);
        chk({tag, "_no_div_valid"}, {63'd0, o_div_valid}, 64'd0);
        i_out_ready = 1'b1;
        tick;
        i_out_ready = 1'b0;
        #1 chk({tag, "_idle"}, {63'd0, o_busy}, 64'd0);
    endtask

    // Multiplier op with an immediately-ready unit returning lo/hi one cycle after issue
    task automatic run_mul(input string tag, input logic [3:0] op,
                           input logic [63:0] lo, input logic [63:0] hi,
                           input logic [1:0] exp_sig, input logic exp_w, input logic [63:0] exp);
        i_in_valid = 1'b1; i_in_op = op; i_in_op1 = 64'd3; i_in_op2 = 64'hFFFF_FFFF_FFFF_FFFE;
        i_mul_ready = 1'b1;
        tick;
        i_in_valid = 1'b0;
        #1;
        chk({tag, "_mul_valid"}, {63'd0, o_mul_valid}, 64'd1);
        chk({tag, "_mul_signed"}, {62'd0, o_mul_signed}, {62'd0, exp_sig});
        chk({tag, "_mulw"}, {63'd0, o_mulw}, {63'd0, exp_w});
        chk({tag, "_op1"}, o_mul_op1, 64'd3);
        tick;
        #1 chk({tag, "_mul_valid_1cyc"}, {63'd0, o_mul_valid}, 64'd0);
        chk({tag, "_no_early_out"}, {63'd0, o_out_valid}, 64'd0);
        i_mul_out_valid = 1'b1; i_result_lo = lo; i_result_hi = hi;
        tick;
        i_mul_out_valid = 1'b0;
        #1;
        chk({tag, "_out_valid"}, {63'd0, o_out_valid}, 64'd1);
        chk({tag, "_res"}, o_out_res, exp);
        i_out_ready = 1'b1;
        tick;
        i_out_ready = 1'b0;
        #1 chk({tag, "_back_idle"}, {63'd0, o_in_ready}, 64'd1);
    endtask

    initial begin
        i_rst_n = 1'b0; i_in_valid = 1'b0; i_flush = 1'b0; i_mul_ready = 1'b0;
        i_mul_out_valid = 1'b0; i_div_ready = 1'b0; i_div_out_valid = 1'b0; i_out_ready = 1'b0;
        i_in_op = 4'd0; i_in_op1 = '0; i_in_op2 = '0; i_result_hi = '0; i_result_lo = '0;
        i_quotient = '0; i_remainder = '0;

        // Reset state
        #1;
        chk("rst_in_ready", {63'd0, o_in_ready}, 64'd0);
        chk("rst_busy", {63'd0, o_busy}, 64'd0);
        chk("rst_out_valid", {63'd0, o_out_valid}, 64'd0);
        chk("rst_out_res", o_out_res, 64'd0);
        tick; tick;
        chk("rst_hold_in_ready", {63'd0, o_in_ready}, 64'd0);
        i_rst_n = 1'b1;
        tick;
        #1 chk("post_rst_in_ready", {63'd0, o_in_ready}, 64'd1);

        // Multiplier paths
        run_mul("mul", 4'd0, 64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFF, 2'b11, 1'b0, 64'hFFFF_FFFF_FFFF_FFFA);
        run_mul("mulhsu", 4'd2, 64'h1111_2222_3333_4444, 64'h0000_0000_0000_0002, 2'b10, 1'b0, 64'h0000_0000_0000_0002);
        run_mul("mulhu", 4'd3, 64'h1, 64'hABCD_0000_0000_1234, 2'b00, 1'b0, 64'hABCD_0000_0000_1234);
        run_mul("mulw", 4'd4, 64'h1234_5678_8000_0001, 64'h0, 2'b11, 1'b1, 64'hFFFF_FFFF_8000_0001);

        // Divide by zero, signed overflow, illegal op
        run_special("divu_zero", 4'd6, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF);
        run_special("remuw_zero", 4'd12, 64'h1_8000_0000, 64'h1_0000_0000, 64'hFFFF_FFFF_8000_0000);
        run_special("rem_zero", 4'd7, 64'h0000_0001_2345_6789, 64'd0, 64'h0000_0001_2345_6789);
        run_special("divw_ovf", 4'd9, 64'h8000_0000, 64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000);
        run_special("rem_ovf", 4'd7, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0);
        run_special("div_ovf", 4'd5, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000);
        run_special("illegal", 4'd13, 64'd5, 64'd3, 64'd0);

        // Divider backpressure: div_ready low for 4 cycles, out_ready low for 3
        i_in_valid = 1'b1; i_in_op = 4'd5; i_in_op1 = 64'd100; i_in_op2 = 64'd7; i_div_ready = 1'b0;
        tick;
        i_in_valid = 1'b0; i_in_op1 = 64'd999; i_in_op2 = 64'd999;
        #1;
        chk("div_signed", {63'd0, o_div_signed}, 64'd1);
        chk("div_divw", {63'd0, o_divw}, 64'd0);
        for (int i = 0; i < 4; i++) begin
            chk("div_bp_valid", {63'd0, o_div_valid}, 64'd1);
            chk("div_bp_op1", o_mul_op1, 64'd100);
            chk("div_bp_op2", o_mul_op2, 64'd7);
            tick;
        end
        i_div_ready = 1'b1;
        #1 chk("div_bp_still_issue", {63'd0, o_div_valid}, 64'd1);
        tick;
        #1 chk("div_valid_drop", {63'd0, o_div_valid}, 64'd0);
        i_div_out_valid = 1'b1; i_quotient = 64'd14; i_remainder = 64'd2;
        tick;
        i_div_out_valid = 1'b0; i_quotient = 64'd77;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("out_bp_res", o_out_res, 64'd14);
            chk("out_bp_busy", {63'd0, o_busy}, 64'd1);
            chk("out_bp_valid", {63'd0, o_out_valid}, 64'd1);
            tick;
        end
        i_out_ready = 1'b1;
        tick;
        i_out_ready = 1'b0;
        #1 chk("out_bp_release", {63'd0, o_out_valid}, 64'd0);

        // REMW through the divider: remainder sign-extended from bit 31
        i_in_valid = 1'b1; i_in_op = 4'd11; i_in_op1 = 64'hFFFF_FFF9; i_in_op2 = 64'd2;
        tick;
        i_in_valid = 1'b0;
        #1 chk("remw_divw", {63'd0, o_divw}, 64'd1);
        tick;
        i_div_out_valid = 1'b1; i_quotient = 64'h0000_0000_FFFF_FFFD; i_remainder = 64'h0000_0000_FFFF_FFFF;
        tick;
        i_div_out_valid = 1'b0;
        #1 chk("remw_res", o_out_res, 64'hFFFF_FFFF_FFFF_FFFF);
        i_out_ready = 1'b1;
        tick;
        i_out_ready = 1'b0;

        // Flush in WAIT_MUL, then a late unit result
        i_in_valid = 1'b1; i_in_op = 4'd0; i_in_op1 = 64'd9; i_in_op2 = 64'd9; i_mul_ready = 1'b1;
        tick;
        i_in_valid = 1'b0;
        tick;
        i_flush = 1'b1;
        #1 chk("flush_unit_flush", {63'd0, o_unit_flush}, 64'd1);
        tick;
        i_flush = 1'b0;
        #1;
        chk("flush_pulse_end", {63'd0, o_unit_flush}, 64'd0);
        chk("flush_idle", {63'd0, o_busy}, 64'd0);
        chk("flush_no_out", {63'd0, o_out_valid}, 64'd0);
        i_mul_out_valid = 1'b1; i_result_lo = 64'd81;
        tick;
        i_mul_out_valid = 1'b0;
        #1;
        chk("late_mul_ignored_valid", {63'd0, o_out_valid}, 64'd0);
        chk("late_mul_ignored_busy", {63'd0, o_busy}, 64'd0);

        // Flush together with in_valid in IDLE: no accept
        i_flush = 1'b1; i_in_valid = 1'b1; i_in_op = 4'd6; i_in_op1 = 64'd1; i_in_op2 = 64'd0;
        #1 chk("flush_blocks_ready", {63'd0, o_in_ready}, 64'd0);
        tick;
        i_flush = 1'b0; i_in_valid = 1'b0;
        #1 chk("flush_no_accept", {63'd0, o_busy}, 64'd0);

        // Reset while in WAIT_DIV
        i_in_valid = 1'b1; i_in_op = 4'd5; i_in_op1 = 64'd50; i_in_op2 = 64'hFFFF_FFFF_FFFF_FFFB;
        i_div_ready = 1'b1;
        tick;
        i_in_valid = 1'b0;
        tick;
        i_rst_n = 1'b0;
        #1;
        chk("arst_busy", {63'd0, o_busy}, 64'd0);
        chk("arst_in_ready", {63'd0, o_in_ready}, 64'd0);
        chk("arst_div_signed", {63'd0, o_div_signed}, 64'd0);
        chk("arst_op1", o_mul_op1, 64'd0);
        chk("arst_out_res", o_out_res, 64'd0);
        tick;
        i_rst_n = 1'b1;
        tick;
        #1 chk("rerst_in_ready", {63'd0, o_in_ready}, 64'd1);
        i_in_valid = 1'b1;
        tick;
        i_in_valid = 1'b0;
        #1 chk("rediv_valid", {63'd0, o_div_valid}, 64'd1);
        tick;
        i_div_out_valid = 1'b1; i_quotient = 64'hFFFF_FFFF_FFFF_FFF6; i_remainder = 64'd0;
        tick;
        i_div_out_valid = 1'b0;
        #1;
        chk("rediv_out_valid", {63'd0, o_out_valid}, 64'd1);
        chk("rediv_res", o_out_res, 64'hFFFF_FFFF_FFFF_FFF6);
        i_out_ready = 1'b1;
        tick;
        i_out_ready = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
